// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg : shared types and encodings for the multi-cycle MIPS control FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mc_if.sv
// ---------------------------------------------------------------------------
// mc_if : instruction fields in, datapath enables/selects out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_we;
  logic       ir_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_we;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       halted;

  modport master (
    input  opcode, funct, zero,
    output pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg,
           reg_we, alu_src_a, alu_src_b, alu_op, halted
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg,
           reg_we, alu_src_a, alu_src_b, alu_op, halted
  );
endinterface

`default_nettype wire

// File: rtl/mc_alu_dec.sv
// ---------------------------------------------------------------------------
// mc_alu_dec : R-type funct to ALU operation, flags unsupported functs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl : multi-cycle MIPS control FSM with memory wait-state counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  mc_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic             wait_done;
  logic [2:0]       fn_alu_op;
  logic             fn_legal;

  mc_alu_dec u_alu_dec (
    .funct  (bus.funct),
    .alu_op (fn_alu_op),
    .legal  (fn_legal)
  );

  assign wait_done = (wcnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Outputs depend on state/wcnt only, except pc_we in BRANCH which follows zero.
  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = '0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.iord       = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_we     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REGB;
    bus.alu_op     = ALU_ADD;
    bus.halted     = 1'b0;

    case (state)
      S_FETCH: begin
        bus.alu_src_b = SRCB_FOUR;
        if (wait_done) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end

      S_DECODE: begin
        bus.alu_src_b = SRCB_IMMSH;
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = fn_legal ? S_EXEC : S_HALT;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_HALT;
        endcase
      end

      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_nxt     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        bus.iord = 1'b1;
        if (wait_done) state_nxt = S_MEMWB;
        else           wcnt_nxt  = wcnt + 1'b1;
      end

      S_MEMWB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_nxt      = S_FETCH;
      end

      S_MEMWR: begin
        bus.iord   = 1'b1;
        bus.mem_we = 1'b1;
        if (wait_done) state_nxt = S_FETCH;
        else           wcnt_nxt  = wcnt + 1'b1;
      end

      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = fn_alu_op;
        state_nxt     = S_ALUWB;
      end

      S_ALUWB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 1'b1;
        state_nxt   = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = PC_ALUOUT;
        bus.pc_we     = bus.zero;
        state_nxt     = S_FETCH;
      end

      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_nxt     = S_ADDIWB;
      end

      S_ADDIWB: begin
        bus.reg_we = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_we  = 1'b1;
        bus.pc_src = PC_JUMP;
        state_nxt  = S_FETCH;
      end

      S_HALT: begin
        bus.halted = 1'b1;
        state_nxt  = S_HALT;
      end

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl : three controllers (MEM_LAT 1..3) checked cycle-by-cycle
// against a per-instruction expected-output schedule.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_ctrl;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n [NDUT];
  logic [5:0]  opc;
  logic [5:0]  fnc;
  logic        zr;
  logic [15:0] outv [NDUT];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          sel   = 0;
  logic [15:0] expq [$];
  logic [15:0] seq  [$];

  always #5 clk = ~clk;

  // DUT index k runs with MEM_LAT = k+1; idle instances are held in reset.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mc_if bus ();
    assign bus.opcode = opc;
    assign bus.funct  = fnc;
    assign bus.zero   = zr;
    mc_ctrl #(.MEM_LAT(g + 1), .CNT_W(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .bus   (bus)
    );
    assign outv[g] = {bus.pc_we, bus.pc_src, bus.iord, bus.mem_we, bus.ir_we,
                      bus.reg_dst, bus.mem_to_reg, bus.reg_we, bus.alu_src_a,
                      bus.alu_src_b, bus.alu_op, bus.halted};
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (MEM_LAT=%0d, t=%0t)", nm, got, exp, sel + 1, $time);
    end
  endtask

  function automatic logic [15:0] ov(logic pcwe, logic [1:0] pcs, logic io, logic mw,
                                     logic iw, logic rd, logic m2r, logic rw, logic sa,
                                     logic [1:0] sb, logic [2:0] aop, logic h);
    return {pcwe, pcs, io, mw, iw, rd, m2r, rw, sa, sb, aop, h};
  endfunction

  // Expected output for every cycle of one instruction, FETCH through write-back.
  task automatic build(input int L, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int nh);
    logic [2:0] aop;
    logic       ok;
    seq.delete();
    for (int i = 0; i < L; i++)
      seq.push_back(ov(i == L - 1, 2'b00, 0, 0, i == L - 1, 0, 0, 0, 0, 2'b01, 3'b000, 0));
    seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 0));
    ok = 1'b1;
    aop = 3'b000;
    case (op)
      6'h23: begin
        seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0));
        for (int i = 0; i < L; i++)
          seq.push_back(ov(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
        seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0));
      end
      6'h2B: begin
        seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0));
        for (int i = 0; i < L; i++)
          seq.push_back(ov(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
      end
      6'h00: begin
        case (fn)
          6'h20: aop = 3'b000;
          6'h22: aop = 3'b001;
          6'h24: aop = 3'b010;
          6'h25: aop = 3'b011;
          6'h2A: aop = 3'b100;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, aop, 0));
          seq.push_back(ov(0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 0));
        end
      end
      6'h04: seq.push_back(ov(z, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0));
      6'h08: begin
        seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0));
        seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0));
      end
      6'h02: seq.push_back(ov(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
      default: ok = 1'b0;
    endcase
    if (!ok)
      for (int i = 0; i < nh; i++)
        seq.push_back(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int k, input bit chk);
    expq.delete();
    for (int j = 0; j < NDUT; j++) rst_n[j] = 1'b0;
    sel = k;
    wait_cyc(2);
    if (chk) begin
      @(negedge clk);
      check("reset_fetch_outputs", {16'h0, outv[k]}, 32'h0010);
      check("reset_halted", {31'h0, outv[k][0]}, 32'h0);
      wait_cyc(1);
    end
    rst_n[k] = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int nh, input int ncyc = -1);
    int n;
    build(sel + 1, op, fn, z, nh);
    n = (ncyc >= 0) ? ncyc : seq.size();
    opc = op;
    fnc = fn;
    zr  = z;
    for (int i = 0; i < n; i++) expq.push_back(seq[i]);
    wait_cyc(n);
  endtask

  function automatic bit legal_op(logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  function automatic bit legal_fn(logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  always @(negedge clk) begin : cmp
    logic [15:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("cycle_outputs", {16'h0, outv[sel]}, {16'h0, e});
    end
  end

  initial begin
    logic [5:0] fn_tab [5];
    logic [5:0] ro;
    logic [5:0] rf;
    int         pick;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
    fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A;
    opc = 6'h00; fnc = 6'h20; zr = 1'b0;
    for (int j = 0; j < NDUT; j++) rst_n[j] = 1'b0;

    // L=1 R-type sub
    reset_dut(0, 0);
    build(1, 6'h00, 6'h22, 0, 0);
    check("model_sub_latency", seq.size(), 4);
    check("model_sub_exec_aluop", {29'h0, seq[2][3:1]}, 32'h1);
    check("model_sub_aluwb", {16'h0, seq[3]}, 32'h0280);
    run_instr(6'h00, 6'h22, 0, 0);
    @(negedge clk);
    check("sub_back_in_fetch", {16'h0, outv[0]}, 32'h8410);

    // L=3 lw, including the literal reset check
    reset_dut(2, 1);
    build(3, 6'h23, 6'h00, 0, 0);
    check("model_lw_latency", seq.size(), 9);
    check("model_lw_irwe_early", {31'h0, seq[1][10]}, 32'h0);
    check("model_lw_irwe_last", {31'h0, seq[2][10]}, 32'h1);
    run_instr(6'h23, 6'h00, 0, 0);
    @(negedge clk);
    check("lw_back_in_fetch", {16'h0, outv[2]}, 32'h0010);

    // beq taken / not taken at L=1
    reset_dut(0, 0);
    build(1, 6'h04, 6'h00, 1, 0);
    check("model_beq_taken", {16'h0, seq[2]}, 32'hA042);
    build(1, 6'h04, 6'h00, 0, 0);
    check("model_beq_not_taken", {16'h0, seq[2]}, 32'h2042);
    run_instr(6'h04, 6'h00, 1, 0);
    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0);

    // illegal opcode: sticky halt, then reset recovers
    run_instr(6'h3F, 6'h00, 0, 20);
    @(negedge clk);
    check("halt_sticky", {31'h0, outv[0][0]}, 32'h1);
    reset_dut(0, 0);
    run_instr(6'h08, 6'h15, 0, 0);

    // L=2 sw, reset asserted during the first MEMWR cycle
    reset_dut(1, 0);
    run_instr(6'h2B, 6'h00, 0, 0, 4);
    check("model_memwr_strobe", {16'h0, seq[4]}, 32'h1800);
    expq.push_back(seq[4]);
    rst_n[1] = 1'b0;
    wait_cyc(1);
    rst_n[1] = 1'b1;
    build(2, 6'h08, 6'h00, 0, 0);
    check("model_fetch_wcnt0", {16'h0, seq[0]}, 32'h0010);
    run_instr(6'h08, 6'h00, 0, 0);

    // randomized instruction streams on every latency
    for (int k = 0; k < NDUT; k++) begin
      reset_dut(k, 0);
      repeat (40) begin
        pick = $urandom_range(0, 9);
        rf = 6'($urandom);
        case (pick)
          0, 1, 2, 3, 4: run_instr(6'h00, fn_tab[pick], 1'($urandom), 0);
          5: run_instr(6'h23, rf, 1'($urandom), 0);
          6: run_instr(6'h2B, rf, 1'($urandom), 0);
          7: run_instr(6'h04, rf, 1'($urandom), 0);
          8: run_instr(6'h08, rf, 1'($urandom), 0);
          default: run_instr(6'h02, rf, 1'($urandom), 0);
        endcase
      end
      if ($urandom_range(0, 1) == 0) begin
        do ro = 6'($urandom); while (legal_op(ro));
        run_instr(ro, 6'h20, 0, 6);
      end else begin
        do rf = 6'($urandom); while (legal_fn(rf));
        run_instr(6'h00, rf, 0, 6);
      end
    end

    wait_cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
